axis_uart_tx_arbiter: RTL

Round-robin, frame-locked AXI-Stream arbiter that shares the single UART transmit byte stream between `N_SRC` independent byte producers, e.g. AXI-Lite response path, debug/log channel and status push. Sits directly upstream of the transceiver's slave stream input. Grants one source per frame (held until `tlast`) and drives a registered output stage. A stall timeout prevents a dead producer from locking the UART.

---
 rtl/axis_uart_tx_arbiter.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/axis_uart_tx_arbiter.sv
// Frame-locked round-robin arbiter sharing one UART TX byte stream between N_SRC producers.
// Define UART_ARB_HDR_EN to prefix every granted frame with a header byte 8'hA0 | grant_id.
module axis_uart_tx_arbiter #(
  parameter int unsigned N_SRC   = 4,
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic               aclk,
  input  logic               aresetn,
  input  logic [N_SRC*8-1:0] s_tdata,
  input  logic [N_SRC-1:0]   s_tvalid,
  input  logic [N_SRC-1:0]   s_tlast,
  output logic [N_SRC-1:0]   s_tready,
  output logic [7:0]         m_tdata,
  output logic               m_tvalid,
  output logic               m_tlast,
  input  logic               m_tready,
  output logic [3:0]         grant_id,
  output logic               busy,
  output logic               err_timeout
);

  localparam int unsigned IdxW = (N_SRC > 1) ? $clog2(N_SRC) : 1;
  localparam int unsigned CntW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [IdxW:0]   NSrc       = (IdxW + 1)'(N_SRC);
  localparam logic [IdxW-1:0] LastIdx    = IdxW'(N_SRC - 1);
  localparam logic [CntW-1:0] TimeoutVal = CntW'(TIMEOUT);

  typedef enum logic [1:0] {
    StIdle,
`ifdef UART_ARB_HDR_EN
    StHdr,
`endif
    StData
  } state_e;

  state_e          state_q, state_d;
  logic [IdxW-1:0] grant_q, grant_d;
  logic [IdxW-1:0] last_grant_q, last_grant_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            err_q, err_d;
  logic            m_tvalid_q, m_tvalid_d;
  logic [7:0]      m_tdata_q, m_tdata_d;
  logic            m_tlast_q, m_tlast_d;

  logic            out_free;
  logic            load;
  logic [7:0]      load_data;
  logic            load_last;
  logic            rr_found;
  logic [IdxW-1:0] rr_pick;
  logic [IdxW:0]   rr_cand;

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    cnt_d        = cnt_q;
    err_d        = 1'b0;
    s_tready     = '0;
    load         = 1'b0;
    load_data    = '0;
    load_last    = 1'b0;
    rr_found     = 1'b0;
    rr_pick      = '0;
    rr_cand      = '0;
    // The output register can take a byte when empty or draining this cycle.
    out_free     = !m_tvalid_q || m_tready;

    // First requester searching upward from last_grant+1, wrapping at N_SRC.
    for (int unsigned i = 1; i <= N_SRC; i++) begin
      rr_cand = (IdxW + 1)'(last_grant_q) + (IdxW + 1)'(i);
      if (rr_cand >= NSrc) rr_cand = rr_cand - NSrc;
      if (!rr_found && s_tvalid[rr_cand[IdxW-1:0]]) begin
        rr_found = 1'b1;
        rr_pick  = rr_cand[IdxW-1:0];
      end
    end

    unique case (state_q)
      StIdle: begin
        cnt_d = '0;
        if (rr_found) begin
          grant_d = rr_pick;
`ifdef UART_ARB_HDR_EN
          state_d = StHdr;
`else
          state_d = StData;
`endif
        end
      end
`ifdef UART_ARB_HDR_EN
      StHdr: begin
        cnt_d = '0;
        if (out_free) begin
          load      = 1'b1;
          load_data = 8'hA0 | 8'(grant_q);
          load_last = 1'b0;
          state_d   = StData;
        end
      end
`endif
      StData: begin
        s_tready[grant_q] = out_free;
        if (s_tvalid[grant_q] && out_free) begin
          load      = 1'b1;
          load_data = s_tdata[{grant_q, 3'b000} +: 8];
          load_last = s_tlast[grant_q];
          cnt_d     = '0;
          if (s_tlast[grant_q]) begin
            last_grant_d = grant_q;
            state_d      = StIdle;
          end
        end else if (!s_tvalid[grant_q]) begin
          // Only producer starvation counts; output backpressure never does.
          cnt_d = cnt_q + 1'b1;
          if ((TIMEOUT != 0) && (cnt_d == TimeoutVal)) begin
            err_d        = 1'b1;
            last_grant_d = grant_q;
            cnt_d        = '0;
            state_d      = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    m_tvalid_d = m_tvalid_q;
    m_tdata_d  = m_tdata_q;
    m_tlast_d  = m_tlast_q;
    if (load) begin
      m_tvalid_d = 1'b1;
      m_tdata_d  = load_data;
      m_tlast_d  = load_last;
    end else if (m_tready) begin
      m_tvalid_d = 1'b0;
    end
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_q      <= StIdle;
      grant_q      <= '0;
      last_grant_q <= LastIdx;
      cnt_q        <= '0;
      err_q        <= 1'b0;
      m_tvalid_q   <= 1'b0;
      m_tdata_q    <= '0;
      m_tlast_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      cnt_q        <= cnt_d;
      err_q        <= err_d;
      m_tvalid_q   <= m_tvalid_d;
      m_tdata_q    <= m_tdata_d;
      m_tlast_q    <= m_tlast_d;
    end
  end

  assign m_tvalid    = m_tvalid_q;
  assign m_tdata     = m_tdata_q;
  assign m_tlast     = m_tlast_q;
  assign grant_id    = 4'(grant_q);
  assign busy        = (state_q != StIdle);
  assign err_timeout = err_q;

endmodule
